// File: rtl/tdc_ctrl_pkg.sv
// Shared types and defaults for the TDC measurement sequencer.
// TDC_CTRL_MINMAX_EN enables per-run hw_min/hw_max tracking.
package tdc_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT,
    DONE
  } tdc_ctrl_state_t;

  localparam int unsigned TDC_N_DEF       = 64;
  localparam int unsigned TDC_CNT_W_DEF   = 8;
  localparam int unsigned TDC_TIMEOUT_DEF = 16;

  function automatic int unsigned hw_width(input int unsigned n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/tdc_stat_accum.sv
// Per-run statistics: sample count, Hamming-weight sum, extrema.
// Extrema registers exist only with TDC_CTRL_MINMAX_EN.
module tdc_stat_accum
  import tdc_ctrl_pkg::*;
#(
  parameter int unsigned HW_W  = 7,
  parameter int unsigned CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    smp_vld,
  input  logic [HW_W-1:0]         hw,
  output logic [CNT_W-1:0]        n_done,
  output logic [HW_W+CNT_W-1:0]   sum,
  output logic [HW_W-1:0]         hw_min,
  output logic [HW_W-1:0]         hw_max
);

  logic [CNT_W-1:0]      n_q;
  logic [HW_W+CNT_W-1:0] sum_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      n_q   <= '0;
      sum_q <= '0;
    end else if (smp_vld) begin
      n_q   <= n_q + CNT_W'(1);
      sum_q <= sum_q + {{CNT_W{1'b0}}, hw};
    end
  end

  assign n_done = n_q;
  assign sum    = sum_q;

`ifdef TDC_CTRL_MINMAX_EN
  logic [HW_W-1:0] min_q;
  logic [HW_W-1:0] max_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      min_q <= '1;
      max_q <= '0;
    end else if (smp_vld) begin
      if (hw < min_q) min_q <= hw;
      if (hw > max_q) max_q <= hw;
    end
  end

  assign hw_min = min_q;
  assign hw_max = max_q;
`else
  assign hw_min = '1;
  assign hw_max = '0;
`endif

endmodule

// File: rtl/tdc_meas_ctrl.sv
// Sequencer running n_meas launch/capture cycles against tdc_top.
// Optional extrema tracking via TDC_CTRL_MINMAX_EN.
module tdc_meas_ctrl
  import tdc_ctrl_pkg::*;
#(
  parameter int unsigned N       = TDC_N_DEF,
  parameter int unsigned CNT_W   = TDC_CNT_W_DEF,
  parameter int unsigned TIMEOUT = TDC_TIMEOUT_DEF,
  localparam int unsigned HW_W   = hw_width(N)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CNT_W-1:0]      n_meas,
  input  logic                  tog_en,
  output logic                  val_in,
  output logic                  pg_tog,
  input  logic [HW_W-1:0]       hw,
  input  logic                  val_out,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout_err,
  output logic [CNT_W-1:0]      n_done,
  output logic [HW_W+CNT_W-1:0] sum,
  output logic [HW_W-1:0]       hw_min,
  output logic [HW_W-1:0]       hw_max
);

  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  tdc_ctrl_state_t  state_q;
  logic [CNT_W-1:0] nmeas_q;
  logic             tog_q;
  logic [TO_W-1:0]  to_cnt_q;
  logic             val_in_q;
  logic             pg_tog_q;
  logic             busy_q;
  logic             done_q;
  logic             terr_q;

  logic clr;
  logic smp_vld;
  logic last_smp;

  assign clr      = (state_q == IDLE) && start;
  assign smp_vld  = (state_q == WAIT) && val_out;
  assign last_smp = (n_done + CNT_W'(1)) == nmeas_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      nmeas_q  <= '0;
      tog_q    <= 1'b0;
      to_cnt_q <= '0;
      val_in_q <= 1'b0;
      pg_tog_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      terr_q   <= 1'b0;
    end else begin
      val_in_q <= 1'b0;
      done_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            nmeas_q <= n_meas;
            tog_q   <= tog_en;
            terr_q  <= 1'b0;
            busy_q  <= 1'b1;
            if (n_meas == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q  <= LAUNCH;
              val_in_q <= 1'b1;
            end
          end
        end
        LAUNCH: begin
          to_cnt_q <= '0;
          state_q  <= WAIT;
        end
        WAIT: begin
          if (val_out) begin
            if (tog_q) pg_tog_q <= ~pg_tog_q;
            if (last_smp) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q  <= LAUNCH;
              val_in_q <= 1'b1;
            end
          end else if (to_cnt_q == TO_LAST) begin
            terr_q  <= 1'b1;
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign val_in      = val_in_q;
  assign pg_tog      = pg_tog_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout_err = terr_q;

  tdc_stat_accum #(
    .HW_W  (HW_W),
    .CNT_W (CNT_W)
  ) u_accum (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .smp_vld (smp_vld),
    .hw      (hw),
    .n_done  (n_done),
    .sum     (sum),
    .hw_min  (hw_min),
    .hw_max  (hw_max)
  );

endmodule

// File: tb/tb_tdc_meas_ctrl.sv
// Directed bench for tdc_meas_ctrl with a small tdc_top response model.
// Extrema expectations follow TDC_CTRL_MINMAX_EN.
module tb_tdc_meas_ctrl;

  localparam int HW_W  = 7;
  localparam int CNT_W = 8;
  localparam int SW    = HW_W + CNT_W;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] n_meas;
  logic             tog_en;
  logic             val_in;
  logic             pg_tog;
  logic [HW_W-1:0]  hw;
  logic             val_out;
  logic             busy;
  logic             done;
  logic             timeout_err;
  logic [CNT_W-1:0] n_done;
  logic [SW-1:0]    sum;
  logic [HW_W-1:0]  hw_min;
  logic [HW_W-1:0]  hw_max;

  int vec = 0;
  int err = 0;

  int m_tbl [0:7];
  int m_cnt;
  int m_lim;
  bit m_const;
  bit vin_seen;
  logic pg_hist [0:15];

  always #5 clk = ~clk;

  tdc_meas_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .n_meas      (n_meas),
    .tog_en      (tog_en),
    .val_in      (val_in),
    .pg_tog      (pg_tog),
    .hw          (hw),
    .val_out     (val_out),
    .busy        (busy),
    .done        (done),
    .timeout_err (timeout_err),
    .n_done      (n_done),
    .sum         (sum),
    .hw_min      (hw_min),
    .hw_max      (hw_max)
  );

  // tdc_top stand-in: answers one cycle after each val_in, up to m_lim times
  always @(posedge clk) begin
    if (val_in) vin_seen <= 1'b1;
    if (val_in && m_cnt < m_lim) begin
      val_out <= 1'b1;
      if (m_const) hw <= 7'd64;
      else hw <= HW_W'(m_tbl[m_cnt]);
      m_cnt <= m_cnt + 1;
    end else begin
      val_out <= 1'b0;
    end
  end

  task automatic model_set(input int lim, input int a, input int b,
                           input int c, input int d);
    m_tbl[0] = a; m_tbl[1] = b; m_tbl[2] = c; m_tbl[3] = d;
    m_lim = lim;
    m_cnt = 0;
    m_const = 1'b0;
    vin_seen = 1'b0;
  endtask

  // edges = index of the edge (start edge = 0) after which done is high
  task automatic run(input int n, input bit tog, input int pulse_at,
                     output int edges);
    @(negedge clk);
    start = 1'b1; n_meas = CNT_W'(n); tog_en = tog;
    edges = -1;
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk);
      @(negedge clk);
      start = (k == pulse_at);
      if (k == pulse_at) n_meas = 8'd1;
      if (k < 16) pg_hist[k] = pg_tog;
      if (done) begin
        edges = k;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; n_meas = '0; tog_en = 1'b0;
    model_set(0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    vec++; if (busy !== 1'b0) begin err++; $display("FAIL rst_busy got %0b want 0", busy); end
    vec++; if (done !== 1'b0) begin err++; $display("FAIL rst_done got %0b want 0", done); end
    vec++; if (val_in !== 1'b0) begin err++; $display("FAIL rst_val_in got %0b want 0", val_in); end
    vec++; if (pg_tog !== 1'b0) begin err++; $display("FAIL rst_pg_tog got %0b want 0", pg_tog); end
    vec++; if (timeout_err !== 1'b0) begin err++; $display("FAIL rst_terr got %0b want 0", timeout_err); end
    vec++; if (sum !== 15'd0) begin err++; $display("FAIL rst_sum got %0d want 0", sum); end
    vec++; if (n_done !== 8'd0) begin err++; $display("FAIL rst_n_done got %0d want 0", n_done); end
    vec++; if (hw_min !== 7'd127) begin err++; $display("FAIL rst_hw_min got %0d want 127", hw_min); end
    vec++; if (hw_max !== 7'd0) begin err++; $display("FAIL rst_hw_max got %0d want 0", hw_max); end
  endtask

  task automatic test_reset_mid_run;
    bit saw_done;
    model_set(4, 10, 20, 30, 40);
    @(negedge clk);
    start = 1'b1; n_meas = 8'd4; tog_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vec++; if (n_done !== 8'd1) begin err++; $display("FAIL mid_pre_n_done got %0d want 1", n_done); end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    vec++; if (busy !== 1'b0) begin err++; $display("FAIL mid_busy got %0b want 0", busy); end
    vec++; if (val_in !== 1'b0) begin err++; $display("FAIL mid_val_in got %0b want 0", val_in); end
    vec++; if (sum !== 15'd0) begin err++; $display("FAIL mid_sum got %0d want 0", sum); end
    vec++; if (n_done !== 8'd0) begin err++; $display("FAIL mid_n_done got %0d want 0", n_done); end
    saw_done = done;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    vec++; if (saw_done !== 1'b0) begin err++; $display("FAIL mid_no_done got %0b want 0", saw_done); end
  endtask

  task automatic test_normal;
    int e;
    model_set(4, 10, 20, 30, 40);
    run(4, 1'b0, -1, e);
    vec++; if (e !== 8) begin err++; $display("FAIL norm_done_edge got %0d want 8", e); end
    vec++; if (sum !== 15'd100) begin err++; $display("FAIL norm_sum got %0d want 100", sum); end
    vec++; if (n_done !== 8'd4) begin err++; $display("FAIL norm_n_done got %0d want 4", n_done); end
    vec++; if (timeout_err !== 1'b0) begin err++; $display("FAIL norm_terr got %0b want 0", timeout_err); end
`ifdef TDC_CTRL_MINMAX_EN
    vec++; if (hw_min !== 7'd10) begin err++; $display("FAIL norm_min got %0d want 10", hw_min); end
    vec++; if (hw_max !== 7'd40) begin err++; $display("FAIL norm_max got %0d want 40", hw_max); end
`else
    vec++; if (hw_min !== 7'd127) begin err++; $display("FAIL norm_min got %0d want 127", hw_min); end
    vec++; if (hw_max !== 7'd0) begin err++; $display("FAIL norm_max got %0d want 0", hw_max); end
`endif
    @(posedge clk);
    @(negedge clk);
    vec++; if (busy !== 1'b0) begin err++; $display("FAIL norm_busy_after got %0b want 0", busy); end
    vec++; if (sum !== 15'd100) begin err++; $display("FAIL norm_sum_hold got %0d want 100", sum); end
  endtask

  task automatic test_toggle;
    int e;
    model_set(3, 1, 2, 3, 0);
    run(3, 1'b1, -1, e);
    vec++; if (e !== 6) begin err++; $display("FAIL tog_done_edge got %0d want 6", e); end
    vec++; if (pg_hist[1] !== 1'b0) begin err++; $display("FAIL tog_e1 got %0b want 0", pg_hist[1]); end
    vec++; if (pg_hist[2] !== 1'b1) begin err++; $display("FAIL tog_e2 got %0b want 1", pg_hist[2]); end
    vec++; if (pg_hist[4] !== 1'b0) begin err++; $display("FAIL tog_e4 got %0b want 0", pg_hist[4]); end
    vec++; if (pg_tog !== 1'b1) begin err++; $display("FAIL tog_end got %0b want 1", pg_tog); end
    model_set(2, 5, 6, 0, 0);
    run(2, 1'b0, -1, e);
    vec++; if (pg_tog !== 1'b1) begin err++; $display("FAIL tog_off got %0b want 1", pg_tog); end
    vec++; if (sum !== 15'd11) begin err++; $display("FAIL tog_off_sum got %0d want 11", sum); end
  endtask

  task automatic test_timeout;
    int e;
    model_set(2, 7, 9, 0, 0);
    run(5, 1'b0, -1, e);
    vec++; if (e !== 21) begin err++; $display("FAIL to_done_edge got %0d want 21", e); end
    vec++; if (timeout_err !== 1'b1) begin err++; $display("FAIL to_terr got %0b want 1", timeout_err); end
    vec++; if (n_done !== 8'd2) begin err++; $display("FAIL to_n_done got %0d want 2", n_done); end
    vec++; if (sum !== 15'd16) begin err++; $display("FAIL to_sum got %0d want 16", sum); end
`ifdef TDC_CTRL_MINMAX_EN
    vec++; if (hw_max !== 7'd9) begin err++; $display("FAIL to_max got %0d want 9", hw_max); end
`endif
  endtask

  task automatic test_zero_and_ignored_start;
    int e;
    model_set(0, 0, 0, 0, 0);
    run(0, 1'b0, -1, e);
    vec++; if (e !== 0) begin err++; $display("FAIL zero_done_edge got %0d want 0", e); end
    vec++; if (sum !== 15'd0) begin err++; $display("FAIL zero_sum got %0d want 0", sum); end
    vec++; if (n_done !== 8'd0) begin err++; $display("FAIL zero_n_done got %0d want 0", n_done); end
    vec++; if (timeout_err !== 1'b0) begin err++; $display("FAIL zero_terr got %0b want 0", timeout_err); end
    @(posedge clk);
    @(negedge clk);
    vec++; if (vin_seen !== 1'b0) begin err++; $display("FAIL zero_val_in got %0b want 0", vin_seen); end
    model_set(4, 3, 50, 1, 8);
    run(4, 1'b0, 3, e);
    vec++; if (e !== 8) begin err++; $display("FAIL ign_done_edge got %0d want 8", e); end
    vec++; if (sum !== 15'd62) begin err++; $display("FAIL ign_sum got %0d want 62", sum); end
    vec++; if (n_done !== 8'd4) begin err++; $display("FAIL ign_n_done got %0d want 4", n_done); end
`ifdef TDC_CTRL_MINMAX_EN
    vec++; if (hw_min !== 7'd1) begin err++; $display("FAIL ign_min got %0d want 1", hw_min); end
    vec++; if (hw_max !== 7'd50) begin err++; $display("FAIL ign_max got %0d want 50", hw_max); end
`endif
  endtask

  task automatic test_full_scale;
    int e;
    model_set(255, 0, 0, 0, 0);
    m_const = 1'b1;
    run(255, 1'b0, -1, e);
    vec++; if (e !== 510) begin err++; $display("FAIL fs_done_edge got %0d want 510", e); end
    vec++; if (sum !== 15'd16320) begin err++; $display("FAIL fs_sum got %0d want 16320", sum); end
    vec++; if (n_done !== 8'd255) begin err++; $display("FAIL fs_n_done got %0d want 255", n_done); end
`ifdef TDC_CTRL_MINMAX_EN
    vec++; if (hw_min !== 7'd64) begin err++; $display("FAIL fs_min got %0d want 64", hw_min); end
    vec++; if (hw_max !== 7'd64) begin err++; $display("FAIL fs_max got %0d want 64", hw_max); end
`else
    vec++; if (hw_min !== 7'd127) begin err++; $display("FAIL fs_min got %0d want 127", hw_min); end
    vec++; if (hw_max !== 7'd0) begin err++; $display("FAIL fs_max got %0d want 0", hw_max); end
`endif
  endtask

  initial begin
    test_reset;
    test_reset_mid_run;
    test_normal;
    test_toggle;
    test_timeout;
    test_zero_and_ignored_start;
    test_full_scale;
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule

// File: doc/tdc_meas_ctrl.md
# tdc_meas_ctrl

Measurement sequencer for the TDC core (`tdc_top`). On a start request it runs a programmed number of launch/capture cycles and drives `val_in` and `pg_tog`. For each cycle it waits for `val_out` with a timeout and accumulates the returned Hamming weight `hw` into a sum (plus optional min/max). It sits between the host/register interface and `tdc_top`, so the host sees a single start/done transaction instead of per-sample handshakes.

## Interface
- `N`, 64: TDC delay-line length; must match `tdc_top`. `HW_W = $clog2(N)+1` is derived.
- `CNT_W`, 8: width of the measurement count; at most 2^CNT_W−1 samples per run.
- `TIMEOUT`, 16: maximum cycles spent in WAIT per sample (≥2).
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle request; honoured only in IDLE.
- `n_meas` in CNT_W: sample count, latched on an accepted `start`.
- `tog_en` in 1: latched on `start`; if 1, `pg_tog` inverts after every accepted sample.
- `val_in` out 1: launch strobe to `tdc_top`.
- `pg_tog` out 1: pulse-generator toggle level to `tdc_top`.
- `hw` in HW_W: Hamming weight from `tdc_top`.
- `val_out` in 1: sample-valid from `tdc_top`.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at the end of a run.
- `timeout_err` out 1: set on abort, cleared by the next accepted `start`.
- `n_done` out CNT_W: number of samples accumulated in the last/current run.
- `sum` out HW_W+CNT_W: accumulated `hw`.
- `hw_min`, `hw_max` out HW_W: extrema of the run (see Configuration).

## Operation
- States: IDLE, LAUNCH, WAIT, DONE.
- IDLE with `start`=1:
  - Latch `n_meas` and `tog_en`.
  - Clear `sum`, `n_done`, `timeout_err`; set `hw_min`=all-ones and `hw_max`=0.
  - If `n_meas`==0, go to DONE; otherwise go to LAUNCH.
- IDLE with `start`=0: stay in IDLE.
- LAUNCH (exactly 1 cycle): `val_in`=1, clear the timeout counter, then go to WAIT.
- WAIT: `val_in`=0. `val_out` is sampled only in this state.
  - `val_out`=1 in a WAIT cycle:
    - `sum += hw` (zero-extended; no overflow is possible by construction).
    - `n_done += 1`; update min/max.
    - Toggle `pg_tog` if `tog_en`.
    - Go to DONE if `n_done+1 == n_meas`, else go to LAUNCH.
  - `val_out`=0 and timeout counter == TIMEOUT−1: set `timeout_err`, go to DONE. The partial `sum`/`n_done` are retained.
  - Otherwise increment the timeout counter.
- DONE (1 cycle): `done`=1, then go to IDLE.
- `val_out` in LAUNCH, DONE or IDLE is ignored.
- `start` while `busy` is ignored; there is no queueing.
- `sum`, `n_done`, `hw_min`, `hw_max` and `timeout_err` hold their values from DONE until the next accepted `start`.
- `pg_tog` is never reset by `start`; it keeps its level across runs.

## Timing
- Reset (sync, overrides everything including mid-run):
  - State → IDLE.
  - `val_in`, `pg_tog`, `busy`, `done`, `timeout_err` = 0.
  - `n_done`, `sum`, `hw_max` = 0; `hw_min` = all-ones.
- `start` at edge t:
  - `busy`=1 from t+1.
  - `val_in`=1 during cycle t+1.
  - The earliest sample is accepted in cycle t+2.
- Per-sample minimum is 2 cycles (LAUNCH + 1 WAIT).
  - Run with `val_out` on the first WAIT cycle each time: `done` at t+1+2·n_meas, `busy` low the cycle after.
- `n_meas`=0: `done` at t+1, `sum`=0, `n_done`=0.
- Outputs reach final values in the same cycle `done` is high.
- A timeout costs TIMEOUT WAIT cycles after LAUNCH.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- `TDC_CTRL_MINMAX_EN` defined: `hw_min`/`hw_max` are tracked per accepted sample (unsigned compare).
- Not defined:
  - No min/max registers are built; `hw_min` is tied to all-ones and `hw_max` to 0.
  - The ports remain so the interface is unchanged.

## Structure
- Package `tdc_ctrl_pkg` holds:
  - the state enum `tdc_ctrl_state_t` (IDLE, LAUNCH, WAIT, DONE);
  - the `HW_W` function/localparam helper;
  - default constants for TIMEOUT and CNT_W.
- Sub-module `tdc_stat_accum` holds the sum, count and min/max registers, with inputs `clr` and `smp_vld`/`hw`.
- The FSM, timeout counter and `pg_tog` live in `tdc_meas_ctrl`.

## Test plan
- Reset mid-run, then restart:
  - Stimulus: `n_meas`=4; assert `rst` during the 2nd WAIT.
  - Required: next cycle IDLE, all outputs at reset values, no `done`.
  - A new `start` then runs normally.
- Normal run:
  - Stimulus: `n_meas`=4; model returns `hw`=10,20,30,40 one cycle after each `val_in`.
  - Required: `done` at t+9, `sum`=100, `n_done`=4, `hw_min`=10, `hw_max`=40 (macro defined), `timeout_err`=0.
- Toggle:
  - Stimulus: `tog_en`=1, `n_meas`=3, `pg_tog`=0 initially.
  - Required: `pg_tog` ends at 1 after 3 toggles, each 1 cycle after its sample.
  - With `tog_en`=0, `pg_tog` is unchanged.
- Timeout:
  - Stimulus: TIMEOUT=16, `n_meas`=5; model answers the first 2 samples (`hw`=7,9), then stays silent.
  - Required: `timeout_err`=1, `n_done`=2, `sum`=16, `done` 16 cycles after the 3rd LAUNCH.
- Zero count and ignored start:
  - Stimulus: `n_meas`=0.
  - Required: `done` at t+1, `sum`=0, `val_in` never asserted.
  - A `start` pulsed while `busy` does not alter the run or its outputs.
- Macro off, full scale:
  - Stimulus: compile without `TDC_CTRL_MINMAX_EN`; run `n_meas`=255 with `hw`=64.
  - Required: `sum`=16320, `hw_min`=127 (all-ones), `hw_max`=0.
